// File: rtl/conv_window_gen_pkg.sv
// Shared types and defaults for the CNN window generator slice.
package cnn_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int K_DEF      = 3;

  typedef enum logic {STRIDE1 = 1'b0, STRIDE2 = 1'b1} stride_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out bundle for conv_window_gen.
interface conv_window_gen_if
  import cnn_pkg::*;
#(
  parameter int FM_DEPTH = 64,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int K        = K_DEF
);

  logic                                     verticle_sync;
  logic                                     mode_in;
  logic                                     data_in_valid;
  logic [FM_DEPTH-1:0][DATA_W-1:0]          data_in;
  logic                                     data_out_valid;
  logic [FM_DEPTH-1:0][K*K-1:0][DATA_W-1:0] data_out;
  logic                                     vs_next;
  logic                                     frame_done;
  logic                                     overflow;

  modport master (
    output verticle_sync, mode_in, data_in_valid, data_in,
    input  data_out_valid, data_out, vs_next, frame_done, overflow
  );

  modport slave (
    input  verticle_sync, mode_in, data_in_valid, data_in,
    output data_out_valid, data_out, vs_next, frame_done, overflow
  );

endinterface

// File: rtl/conv_window_gen_line_buffer.sv
// One-row delay line: dout is the word written DEPTH writes ago.
module line_buffer #(
  parameter int DEPTH = 56,
  parameter int WIDTH = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr;

  // Read-before-write at the same slot gives the previous row's pixel.
  assign dout = mem[ptr];

  always_ff @(posedge clk) begin
    if (we) mem[ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     ptr <= '0;
    else if (we) ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  end

endmodule

// File: rtl/conv_window_gen.sv
// KxK sliding-window generator over a raster pixel stream, stride 1 or 2.
module conv_window_gen
  import cnn_pkg::*;
#(
  parameter int FM_DEPTH  = 64,
  parameter int FM_WIDTH  = 56,
  parameter int FM_HEIGHT = 56,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int K         = K_DEF
) (
  input logic              clk,
  input logic              rst,
  conv_window_gen_if.slave bus
);

  localparam int   PW   = FM_DEPTH * DATA_W;
  localparam int   CW   = (FM_WIDTH  > 1) ? $clog2(FM_WIDTH)  : 1;
  localparam int   RW   = (FM_HEIGHT > 1) ? $clog2(FM_HEIGHT) : 1;
  localparam logic KPAR = 1'((K - 1) % 2);

  typedef logic [FM_DEPTH-1:0][DATA_W-1:0] pix_t;

  state_t        state;
  stride_t       mode, cur_mode;
  logic [CW-1:0] col, cur_col;
  logic [RW-1:0] row, cur_row;
  logic          first_pend;
  logic          accept, emit, last_pix;

  pix_t          win     [K][K];
  pix_t          win_nx  [K][K];
  pix_t          new_col [K];
  logic [PW-1:0] lb_in   [K-1];
  logic [PW-1:0] lb_out  [K-1];
  logic [FM_DEPTH-1:0][K*K-1:0][DATA_W-1:0] win_flat, dout_r;
  logic          dov_r, vsn_r, fd_r, ovf_r;

  for (genvar i = 0; i < K - 1; i++) begin : g_lb
    if (i == 0) begin : g_head
      assign lb_in[i] = bus.data_in;
    end else begin : g_tail
      assign lb_in[i] = lb_out[i-1];
    end
    line_buffer #(.DEPTH(FM_WIDTH), .WIDTH(PW)) u_lb (
      .clk  (clk),
      .rst  (rst),
      .we   (accept),
      .din  (lb_in[i]),
      .dout (lb_out[i])
    );
  end

  // A sync-cycle pixel is (0,0) of the new frame, so position/mode are muxed here.
  always_comb begin
    cur_row  = bus.verticle_sync ? '0 : row;
    cur_col  = bus.verticle_sync ? '0 : col;
    cur_mode = bus.verticle_sync ? stride_t'(bus.mode_in) : mode;
    accept   = bus.data_in_valid && (bus.verticle_sync || state == RUN);
    last_pix = (cur_row == RW'(FM_HEIGHT - 1)) && (cur_col == CW'(FM_WIDTH - 1));
    emit     = accept && (cur_row >= RW'(K - 1)) && (cur_col >= CW'(K - 1)) &&
               (cur_mode == STRIDE1 || (cur_row[0] == KPAR && cur_col[0] == KPAR));

    new_col[K-1] = bus.data_in;
    for (int unsigned r = 0; r < K - 1; r++) new_col[K-2-r] = lb_out[r];

    for (int unsigned r = 0; r < K; r++) begin
      for (int unsigned c = 0; c < K - 1; c++) win_nx[r][c] = win[r][c+1];
      win_nx[r][K-1] = new_col[r];
    end

    win_flat = '0;
    for (int unsigned r = 0; r < K; r++)
      for (int unsigned c = 0; c < K; c++)
        for (int unsigned ch = 0; ch < FM_DEPTH; ch++)
          win_flat[ch][r*K+c] = win_nx[r][c][ch];
  end

  always_ff @(posedge clk) begin
    if (accept) win <= win_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      mode       <= STRIDE1;
      row        <= '0;
      col        <= '0;
      first_pend <= 1'b0;
      dov_r      <= 1'b0;
      vsn_r      <= 1'b0;
      fd_r       <= 1'b0;
      ovf_r      <= 1'b0;
      dout_r     <= '0;
    end else begin
      dov_r <= emit;
      vsn_r <= emit && (bus.verticle_sync || first_pend);
      fd_r  <= accept && last_pix;
      if (emit) dout_r <= win_flat;

      if (bus.verticle_sync) begin
        state      <= RUN;
        mode       <= stride_t'(bus.mode_in);
        row        <= '0;
        col        <= '0;
        ovf_r      <= 1'b0;
        first_pend <= 1'b1;
      end else if (state == DONE && bus.data_in_valid) begin
        ovf_r <= 1'b1;
      end

      if (emit) first_pend <= 1'b0;

      if (accept) begin
        if (last_pix) begin
          state <= DONE;
          row   <= '0;
          col   <= '0;
        end else if (cur_col == CW'(FM_WIDTH - 1)) begin
          col <= '0;
          row <= cur_row + 1'b1;
        end else begin
          col <= cur_col + 1'b1;
          row <= cur_row;
        end
      end
    end
  end

  assign bus.data_out_valid = dov_r;
  assign bus.vs_next        = vsn_r;
  assign bus.frame_done     = fd_r;
  assign bus.overflow       = ovf_r;
  assign bus.data_out       = dout_r;

endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen against an image-indexed window model.
module tb_conv_window_gen;
  import cnn_pkg::*;

  localparam int D = 4, W = 8, H = 6, KK = 3, DW = 16, T = KK * KK;
  typedef logic [D-1:0][T-1:0][DW-1:0] win_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_window_gen_if #(.FM_DEPTH(D), .DATA_W(DW), .K(KK)) bus ();

  conv_window_gen #(
    .FM_DEPTH (D),
    .FM_WIDTH (W),
    .FM_HEIGHT(H),
    .DATA_W   (DW),
    .K        (KK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0, bad = 0;
  logic [DW-1:0] img [H][W][D];
  logic exp_vld, exp_vs, exp_fd;
  win_t exp_hold, first_win;
  int   win_cnt;

  function automatic int exp_windows(input int stride);
    if (stride == 0) return (H - KK + 1) * (W - KK + 1);
    return ((H - KK + 2) / 2) * ((W - KK + 2) / 2);
  endfunction

  // Drives one frame (optionally gapped / mode-toggled / aborted by reset) and checks every cycle.
  task automatic run_frame(input int stride, input bit gaps, input bit toggle,
                           input int abort_at, input bit pattern);
    int p, cyc, tail, r, c;
    bit v, seen_first;
    for (int rr = 0; rr < H; rr++)
      for (int cc = 0; cc < W; cc++)
        for (int ch = 0; ch < D; ch++)
          img[rr][cc][ch] = pattern ? DW'(rr * 16 + cc + ch * 256) : DW'($urandom);
    p = 0; cyc = 0; tail = 0; seen_first = 0; win_cnt = 0;
    exp_vld = 0; exp_vs = 0; exp_fd = 0;
    while (tail < 2) begin
      @(negedge clk);
      if (cyc > 0) begin
        total++;
        if (bus.data_out_valid !== exp_vld) begin
          bad++; $display("FAIL data_out_valid cyc=%0d got=%b exp=%b", cyc, bus.data_out_valid, exp_vld);
        end
        total++;
        if (bus.vs_next !== exp_vs) begin
          bad++; $display("FAIL vs_next cyc=%0d got=%b exp=%b", cyc, bus.vs_next, exp_vs);
        end
        total++;
        if (bus.frame_done !== exp_fd) begin
          bad++; $display("FAIL frame_done cyc=%0d got=%b exp=%b", cyc, bus.frame_done, exp_fd);
        end
        total++;
        if (bus.overflow !== 1'b0) begin
          bad++; $display("FAIL overflow_in_frame cyc=%0d got=%b exp=0", cyc, bus.overflow);
        end
        total++;
        if (bus.data_out !== exp_hold) begin
          bad++; $display("FAIL data_out cyc=%0d got=%h exp=%h", cyc, bus.data_out, exp_hold);
        end
        if (bus.data_out_valid === 1'b1) begin
          win_cnt++;
          if (bus.vs_next === 1'b1) first_win = bus.data_out;
        end
      end
      if (abort_at >= 0 && p == abort_at) begin
        rst = 1'b1;
        bus.data_in_valid = 1'b0;
        bus.verticle_sync = 1'b0;
        return;
      end
      v = (p < H * W) && ((cyc == 0) || !gaps || (cyc % 2 == 0));
      bus.verticle_sync = (cyc == 0);
      bus.mode_in = (cyc == 0 || !toggle) ? 1'(stride) : 1'($urandom);
      bus.data_in_valid = v;
      exp_vld = 0; exp_vs = 0; exp_fd = 0;
      if (v) begin
        r = p / W; c = p % W;
        for (int ch = 0; ch < D; ch++) bus.data_in[ch] = img[r][c][ch];
        if (r >= KK - 1 && c >= KK - 1 &&
            (stride == 0 || ((r - (KK - 1)) % 2 == 0 && (c - (KK - 1)) % 2 == 0))) begin
          exp_vld = 1;
          exp_vs  = !seen_first;
          seen_first = 1;
          for (int ch = 0; ch < D; ch++)
            for (int i = 0; i < KK; i++)
              for (int j = 0; j < KK; j++)
                exp_hold[ch][i*KK+j] = img[r-KK+1+i][c-KK+1+j][ch];
        end
        exp_fd = (p == H * W - 1);
        p++;
      end else begin
        bus.data_in = {D{DW'($urandom)}};
      end
      if (p == H * W && !v) tail++;
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.verticle_sync = 0; bus.mode_in = 0; bus.data_in_valid = 0; bus.data_in = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.data_out_valid, bus.vs_next, bus.frame_done, bus.overflow} !== 4'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=0000",
                      {bus.data_out_valid, bus.vs_next, bus.frame_done, bus.overflow});
    end
    total++;
    if (bus.data_out !== '0) begin
      bad++; $display("FAIL reset_data_out got=%h exp=0", bus.data_out);
    end
    exp_hold = '0;
    rst = 1'b0;
  endtask

  task automatic test_stride1();
    logic [DW-1:0] taps [T];
    taps = '{16'h00, 16'h01, 16'h02, 16'h10, 16'h11, 16'h12, 16'h20, 16'h21, 16'h22};
    run_frame(0, 0, 0, -1, 1);
    total++;
    if (win_cnt != exp_windows(0)) begin
      bad++; $display("FAIL stride1_count got=%0d exp=%0d", win_cnt, exp_windows(0));
    end
    for (int t = 0; t < T; t++) begin
      total++;
      if (first_win[0][t] !== taps[t]) begin
        bad++; $display("FAIL first_win_ch0_tap%0d got=%h exp=%h", t, first_win[0][t], taps[t]);
      end
      total++;
      if (first_win[3][t] !== taps[t] + 16'h300) begin
        bad++; $display("FAIL first_win_ch3_tap%0d got=%h exp=%h", t, first_win[3][t], taps[t] + 16'h300);
      end
    end
  endtask

  task automatic test_stride2();
    run_frame(1, 0, 0, -1, 1);
    total++;
    if (win_cnt != exp_windows(1)) begin
      bad++; $display("FAIL stride2_count got=%0d exp=%0d", win_cnt, exp_windows(1));
    end
    total++;
    if (bus.data_out[0][T-1] !== 16'h46) begin
      bad++; $display("FAIL stride2_last_tap8 got=%h exp=0046", bus.data_out[0][T-1]);
    end
    run_frame(1, 1, 0, -1, 0);
    total++;
    if (win_cnt != exp_windows(1)) begin
      bad++; $display("FAIL stride2_rand_count got=%0d exp=%0d", win_cnt, exp_windows(1));
    end
  endtask

  task automatic test_gaps();
    run_frame(0, 1, 0, -1, 0);
    total++;
    if (win_cnt != exp_windows(0)) begin
      bad++; $display("FAIL gaps_count got=%0d exp=%0d", win_cnt, exp_windows(0));
    end
  endtask

  task automatic test_mode_toggle();
    run_frame(0, 0, 1, -1, 0);
    total++;
    if (win_cnt != exp_windows(0)) begin
      bad++; $display("FAIL toggle_count got=%0d exp=%0d", win_cnt, exp_windows(0));
    end
  endtask

  task automatic test_overflow();
    run_frame(0, 0, 0, -1, 0);
    for (int i = 0; i < 5; i++) begin
      bus.data_in_valid = 1'b1;
      bus.data_in = {D{DW'($urandom)}};
      @(negedge clk);
      total++;
      if (bus.data_out_valid !== 1'b0) begin
        bad++; $display("FAIL overflow_window i=%0d got=%b exp=0", i, bus.data_out_valid);
      end
    end
    bus.data_in_valid = 1'b0;
    total++;
    if (bus.overflow !== 1'b1) begin
      bad++; $display("FAIL overflow_set got=%b exp=1", bus.overflow);
    end
    total++;
    if (bus.data_out !== exp_hold) begin
      bad++; $display("FAIL overflow_hold got=%h exp=%h", bus.data_out, exp_hold);
    end
    bus.verticle_sync = 1'b1;
    @(negedge clk);
    bus.verticle_sync = 1'b0;
    total++;
    if (bus.overflow !== 1'b0) begin
      bad++; $display("FAIL overflow_clear got=%b exp=0", bus.overflow);
    end
  endtask

  task automatic test_reset_mid_frame();
    run_frame(0, 0, 0, 30, 0);
    @(negedge clk);
    total++;
    if ({bus.data_out_valid, bus.vs_next, bus.frame_done, bus.overflow} !== 4'b0) begin
      bad++; $display("FAIL midrst_flags got=%b exp=0000",
                      {bus.data_out_valid, bus.vs_next, bus.frame_done, bus.overflow});
    end
    total++;
    if (bus.data_out !== '0) begin
      bad++; $display("FAIL midrst_data_out got=%h exp=0", bus.data_out);
    end
    exp_hold = '0;
    rst = 1'b0;
    for (int i = 0; i < 2 * W + 4; i++) begin
      bus.data_in_valid = 1'b1;
      bus.data_in = {D{DW'($urandom)}};
      @(negedge clk);
      total++;
      if (bus.data_out_valid !== 1'b0 || bus.overflow !== 1'b0) begin
        bad++; $display("FAIL idle_ignore i=%0d got_valid=%b got_ovf=%b exp=0 0",
                        i, bus.data_out_valid, bus.overflow);
      end
    end
    bus.data_in_valid = 1'b0;
    run_frame(0, 0, 0, -1, 0);
    total++;
    if (win_cnt != exp_windows(0)) begin
      bad++; $display("FAIL midrst_count got=%0d exp=%0d", win_cnt, exp_windows(0));
    end
  endtask

  task automatic test_back_to_back();
    run_frame(1, 0, 0, -1, 0);
    run_frame(0, 1, 1, -1, 0);
    total++;
    if (win_cnt != exp_windows(0)) begin
      bad++; $display("FAIL b2b_count got=%0d exp=%0d", win_cnt, exp_windows(0));
    end
  endtask

  initial begin
    test_reset();
    test_stride1();
    test_stride2();
    test_gaps();
    test_mode_toggle();
    test_overflow();
    test_reset_mid_frame();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/conv_window_gen.md
CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

Interface
REQ-001 Parameters (name, default, meaning): FM_DEPTH 64 channels; FM_WIDTH 56 pixels/row; FM_HEIGHT 56 rows/frame; DATA_W 16 bits/sample; K 3 kernel edge (K*K taps).
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 verticle_sync  in  1  one-cycle frame-start pulse.
REQ-005 mode_in  in  1  stride select: 0 = stride 1, 1 = stride 2.
REQ-006 data_in_valid  in  1  data_in carries one pixel (all channels).
REQ-007 data_in  in  [FM_DEPTH][DATA_W]  pixel, raster order.
REQ-008 data_out_valid  out  1  data_out holds a complete window.
REQ-009 data_out  out  [FM_DEPTH][K*K][DATA_W]  window, tap 0 = top-left, row-major, tap K*K-1 = newest pixel.
REQ-010 vs_next  out  1  pulse with the first window of each frame.
REQ-011 frame_done  out  1  pulse one cycle after the last pixel of a frame is accepted.
REQ-012 overflow  out  1  sticky: pixel received after frame complete.

Function
REQ-013 FSM states: IDLE, RUN, DONE; IDLE -> RUN on verticle_sync; RUN -> DONE on acceptance of pixel (FM_HEIGHT-1, FM_WIDTH-1); any state -> RUN on verticle_sync.
REQ-014 verticle_sync clears row/col counters and overflow, latches mode_in; a data_in_valid in the same cycle is pixel (0,0) of the new frame.
REQ-015 mode_in is sampled only at verticle_sync; mid-frame changes have no effect.
REQ-016 In RUN each data_in_valid writes the pixel into K-1 line buffers plus the KxK window shift registers and advances col; col wraps FM_WIDTH-1 -> 0 with row+1.
REQ-017 Valid (unpadded) convolution: a window is emitted when the accepted pixel has row >= K-1 and col >= K-1; in stride-2 mode additionally (row-(K-1)) and (col-(K-1)) both even.
REQ-018 Latency: data_out_valid and data_out asserted exactly one cycle after the completing data_in_valid, for one cycle.
REQ-019 data_out holds its last value when data_out_valid is low.
REQ-020 Gaps in data_in_valid stall all state; no window is emitted and none is lost.
REQ-021 Windows never mix rows across the wrap: taps come from rows row-K+1..row, cols col-K+1..col.
REQ-022 vs_next asserts together with data_out_valid for the first window of the frame only.
REQ-023 data_in_valid in IDLE is ignored without flagging; in DONE it is ignored and sets overflow until the next verticle_sync or rst.
REQ-024 Window count per frame: stride 1 (H-K+1)*(W-K+1); stride 2 ceil((H-K+1)/2)*ceil((W-K+1)/2).

Reset
REQ-025 rst asserted: FSM IDLE, counters 0, mode stride 1, data_out_valid/vs_next/frame_done/overflow 0, data_out all zero.
REQ-026 rst mid-frame aborts the frame; no window is emitted until a new verticle_sync; line-buffer contents need not be cleared.

Structure
REQ-027 Package cnn_pkg holds DATA_W default, K default, stride enum (STRIDE1, STRIDE2) and FSM state typedef.
REQ-028 One sub-module, line_buffer: FM_WIDTH-deep, FM_DEPTH*DATA_W-wide shift/ring buffer with write-enable, instantiated K-1 times.

Verification (FM_DEPTH=4, FM_WIDTH=8, FM_HEIGHT=6, K=3; ch0 pixel = row*16+col, chN = ch0+N*256)
REQ-029 Stride 1, continuous valid -> 24 windows; first one cycle after pixel 18 with ch0 taps {00,01,02,10,11,12,20,21,22}, vs_next high; frame_done one cycle after pixel 47.
REQ-030 Stride 2 -> 6 windows, centers-bottom-right at (2,2),(2,4),(2,6),(4,2),(4,4),(4,6); last ch0 tap8 = 0x46.
REQ-031 Valid toggling 1-0-1-0 through the frame -> identical window sequence to REQ-029, each one cycle after its completing pixel.
REQ-032 mode_in toggled mid-frame after stride-1 verticle_sync -> still 24 windows.
REQ-033 5 extra pixels after frame end -> overflow = 1, no windows; next verticle_sync -> overflow = 0.
REQ-034 rst at pixel 30 then new verticle_sync and full frame -> outputs 0 during reset, then exactly 24 correct windows with no stale taps.
